// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, NOP, forwarding selects, hazard FSM states.
// Decoded-instruction struct and the forwarding priority helper live here too.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_DM = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       dest_valid;
    logic [4:0] dest;
    logic       reads_rs;
    logic       reads_rt;
    logic       is_lw;
    logic       is_halt;
    logic [4:0] rs;
    logic [4:0] rt;
  } dec_t;

  // DM is the younger producer, so it wins over WB.
  function automatic fwd_sel_e fwd_pick(input dec_t dm, input dec_t wb, input logic [4:0] src);
    if (dm.dest_valid && (dm.dest == src)) return FWD_DM;
    if (wb.dest_valid && (wb.dest == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ins_decode.sv
// Instruction field decode for hazard checks: destination and source usage.
// Purely combinational, zero latency; no flow control.
module ins_decode
  import pipe_pkg::*;
#(
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic [31:0] ins,
  output dec_t        dec
);

  logic [5:0] op;
  logic [4:0] dest_raw;
  logic       has_dest;
  logic       unused_ins;

  assign op         = ins[31:26];
  assign unused_ins = ^ins[10:0];

  always_comb begin
    has_dest = 1'b0;
    dest_raw = 5'd0;
    if (op == OP_RTYPE) begin
      has_dest = 1'b1;
      dest_raw = ins[15:11];
    end else if ((op[5:3] == 3'b001) || (op == OP_LW)) begin
      has_dest = 1'b1;
      dest_raw = ins[20:16];
    end
  end

  // $0 is hardwired, so a write to it never creates a dependency.
  assign dec.dest_valid = has_dest && (dest_raw != 5'd0);
  assign dec.dest       = dest_raw;
  assign dec.reads_rs   = !((op == OP_J) || (op == OP_JAL) || (op == HALT_OP));
  assign dec.reads_rt   = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign dec.is_lw      = (op == OP_LW);
  assign dec.is_halt    = (op == HALT_OP);
  assign dec.rs         = ins[25:21];
  assign dec.rt         = ins[20:16];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, redirect flush, forwarding, halt drain, debug counters.
// Controls and forwarding are combinational (0 cycles); state, finish and counters are registered; no backpressure.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_ins,
  input  logic [31:0]      ex_ins,
  input  logic [31:0]      dm_ins,
  input  logic [31:0]      wb_ins,
  input  logic             ex_redirect,
  output logic             pc_hold,
  output logic             id_hold,
  output logic             id_flush,
  output logic             ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             finish,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  dec_t      id_dec, ex_dec, dm_dec, wb_dec;
  hz_state_e state, state_nxt;
  logic      load_use;
  logic      stall_evt, flush_evt, set_finish;
  logic      unused_dec;

  ins_decode #(.HALT_OP(HALT_OP)) u_id_dec (.ins(id_ins), .dec(id_dec));
  ins_decode #(.HALT_OP(HALT_OP)) u_ex_dec (.ins(ex_ins), .dec(ex_dec));
  ins_decode #(.HALT_OP(HALT_OP)) u_dm_dec (.ins(dm_ins), .dec(dm_dec));
  ins_decode #(.HALT_OP(HALT_OP)) u_wb_dec (.ins(wb_ins), .dec(wb_dec));

  assign unused_dec = ^{id_dec, ex_dec, dm_dec, wb_dec};

  assign load_use = ex_dec.is_lw && (ex_dec.rt != 5'd0) &&
                    ((id_dec.reads_rs && (id_dec.rs == ex_dec.rt)) ||
                     (id_dec.reads_rt && (id_dec.rt == ex_dec.rt)));

  assign fwd_a = fwd_pick(dm_dec, wb_dec, ex_dec.rs);
  assign fwd_b = fwd_pick(dm_dec, wb_dec, ex_dec.rt);

  always_comb begin
    state_nxt  = state;
    pc_hold    = 1'b0;
    id_hold    = 1'b0;
    id_flush   = 1'b0;
    ex_bubble  = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    set_finish = 1'b0;
    case (state)
      ST_RUN: begin
        // A taken redirect squashes whatever sits in ID, including a stall or a halt.
        if (ex_redirect) begin
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
          flush_evt = 1'b1;
        end else if (load_use) begin
          pc_hold   = 1'b1;
          id_hold   = 1'b1;
          ex_bubble = 1'b1;
          stall_evt = 1'b1;
        end else if (id_dec.is_halt) begin
          pc_hold   = 1'b1;
          id_flush  = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pc_hold  = 1'b1;
        id_flush = 1'b1;
        if (wb_dec.is_halt) begin
          set_finish = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        pc_hold  = 1'b1;
        id_flush = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      finish    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (set_finish) finish <= 1'b1;
      if (stall_evt && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle expectations queued at drive time, popped at negedge.
// A second instance with 2-bit counters exercises saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] id_ins = '0, ex_ins = '0, dm_ins = '0, wb_ins = '0;
  logic        ex_redirect = 1'b0;

  logic        pc_hold, id_hold, id_flush, ex_bubble, finish;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_hold, s_id_hold, s_id_flush, s_ex_bubble, s_finish;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [8:0]  obs_ctrl;
  logic [31:0] obs_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_ins(id_ins), .ex_ins(ex_ins), .dm_ins(dm_ins), .wb_ins(wb_ins),
    .ex_redirect(ex_redirect), .pc_hold(pc_hold), .id_hold(id_hold), .id_flush(id_flush),
    .ex_bubble(ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .finish(finish),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_ins(id_ins), .ex_ins(ex_ins), .dm_ins(dm_ins), .wb_ins(wb_ins),
    .ex_redirect(ex_redirect), .pc_hold(s_pc_hold), .id_hold(s_id_hold), .id_flush(s_id_flush),
    .ex_bubble(s_ex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .finish(s_finish),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  assign obs_ctrl = {pc_hold, id_hold, id_flush, ex_bubble, fwd_a, fwd_b, finish};
  assign obs_cnt  = {stall_cnt, flush_cnt};

  localparam logic [31:0] NOP_I  = 32'h0000_0000;
  localparam logic [31:0] HALT_I = 32'hFC00_0000;
  localparam logic [31:0] LW21   = {6'h23, 5'd1, 5'd2, 16'd0};          // lw  $2,0($1)
  localparam logic [31:0] ADD324 = {6'h00, 5'd2, 5'd4, 5'd3, 11'h020};  // add $3,$2,$4
  localparam logic [31:0] ADD125 = {6'h00, 5'd1, 5'd2, 5'd5, 11'h020};  // add $5,$1,$2
  localparam logic [31:0] ADDI05 = {6'h08, 5'd0, 5'd5, 16'd1};          // addi $5,$0,1
  localparam logic [31:0] SUB655 = {6'h00, 5'd5, 5'd5, 5'd6, 11'h022};  // sub $6,$5,$5
  localparam logic [31:0] ADD758 = {6'h00, 5'd7, 5'd5, 5'd8, 11'h020};  // add $8,$7,$5
  localparam logic [31:0] ADD127 = {6'h00, 5'd1, 5'd2, 5'd7, 11'h020};  // add $7,$1,$2
  localparam logic [31:0] ADD120 = {6'h00, 5'd1, 5'd2, 5'd0, 11'h020};  // add $0,$1,$2
  localparam logic [31:0] ADDI00 = {6'h08, 5'd0, 5'd0, 16'd1};          // addi $0,$0,1
  localparam logic [31:0] SW15   = {6'h2B, 5'd1, 5'd5, 16'd0};          // sw  $5,0($1)
  localparam logic [31:0] BEQ55  = {6'h04, 5'd5, 5'd5, 16'd4};          // beq $5,$5
  localparam logic [31:0] LW15   = {6'h23, 5'd1, 5'd5, 16'd0};          // lw  $5,0($1)

  typedef struct {
    logic [31:0] id, ex, dm, wb;
    logic        redir;
    logic [8:0]  ctrl;
    logic [15:0] stall, flush;
  } row_t;

  typedef struct {
    logic [8:0]  ctrl;
    logic [15:0] stall, flush;
  } exp_t;

  exp_t sb[$];

  function automatic logic [8:0] ctl(int ph, int ih, int fl, int eb, int fa, int fb, int fin);
    return {ph[0], ih[0], fl[0], eb[0], fa[1:0], fb[1:0], fin[0]};
  endfunction

  task automatic apply(input row_t r);
    id_ins = r.id; ex_ins = r.ex; dm_ins = r.dm; wb_ins = r.wb; ex_redirect = r.redir;
    sb.push_back(exp_t'{r.ctrl, r.stall, r.flush});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if (obs_ctrl !== ctl(0,0,0,0,0,0,0)) begin
      n_fail++; $display("FAIL reset ctrl: got %b want %b", obs_ctrl, ctl(0,0,0,0,0,0,0));
    end
    n_checks++;
    if (obs_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset counters: got %h want 00000000", obs_cnt);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e;
    rows.push_back(row_t'{ADD324, LW21,   NOP_I,  NOP_I, 1'b0, ctl(1,1,0,1,0,0,0), 16'd0, 16'd0});
    rows.push_back(row_t'{NOP_I,  ADD324, LW21,   NOP_I, 1'b0, ctl(0,0,0,0,1,0,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I,  NOP_I,  ADD324, LW21,  1'b0, ctl(0,0,0,0,0,0,0), 16'd1, 16'd0});
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL load_use ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      n_checks++;
      if (obs_cnt !== {e.stall, e.flush}) begin
        n_fail++; $display("FAIL load_use counters row %0d: got %h want %h", i, obs_cnt, {e.stall, e.flush});
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_forwarding();
    row_t rows[$];
    exp_t e;
    rows.push_back(row_t'{NOP_I, SUB655, ADD125, ADDI05, 1'b0, ctl(0,0,0,0,1,1,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I, SUB655, NOP_I,  ADDI05, 1'b0, ctl(0,0,0,0,2,2,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I, ADD758, ADD127, ADDI05, 1'b0, ctl(0,0,0,0,1,2,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I, NOP_I,  ADD120, ADDI00, 1'b0, ctl(0,0,0,0,0,0,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I, SUB655, SW15,   BEQ55,  1'b0, ctl(0,0,0,0,0,0,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I, SUB655, NOP_I,  LW15,   1'b0, ctl(0,0,0,0,2,2,0), 16'd1, 16'd0});
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL forwarding ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_redirect_over_stall();
    row_t rows[$];
    exp_t e;
    rows.push_back(row_t'{ADD324, LW21,  NOP_I, NOP_I, 1'b1, ctl(0,0,1,1,0,0,0), 16'd1, 16'd0});
    rows.push_back(row_t'{NOP_I,  NOP_I, NOP_I, NOP_I, 1'b0, ctl(0,0,0,0,0,0,0), 16'd1, 16'd1});
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL redirect_stall ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      n_checks++;
      if (obs_cnt !== {e.stall, e.flush}) begin
        n_fail++; $display("FAIL redirect_stall counters row %0d: got %h want %h", i, obs_cnt, {e.stall, e.flush});
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_redirect_kills_halt();
    row_t rows[$];
    exp_t e;
    rows.push_back(row_t'{HALT_I, NOP_I, NOP_I, NOP_I, 1'b1, ctl(0,0,1,1,0,0,0), 16'd1, 16'd1});
    rows.push_back(row_t'{NOP_I,  NOP_I, NOP_I, NOP_I, 1'b0, ctl(0,0,0,0,0,0,0), 16'd1, 16'd2});
    rows.push_back(row_t'{ADD324, LW21,  NOP_I, NOP_I, 1'b0, ctl(1,1,0,1,0,0,0), 16'd1, 16'd2});
    rows.push_back(row_t'{NOP_I,  NOP_I, NOP_I, NOP_I, 1'b0, ctl(0,0,0,0,0,0,0), 16'd2, 16'd2});
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL redirect_halt ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      n_checks++;
      if (obs_cnt !== {e.stall, e.flush}) begin
        n_fail++; $display("FAIL redirect_halt counters row %0d: got %h want %h", i, obs_cnt, {e.stall, e.flush});
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_halt_drain();
    row_t rows[$];
    exp_t e;
    rows.push_back(row_t'{HALT_I, NOP_I,  NOP_I,  NOP_I,  1'b0, ctl(1,0,1,0,0,0,0), 16'd2, 16'd2});
    rows.push_back(row_t'{ADD324, HALT_I, NOP_I,  NOP_I,  1'b1, ctl(1,0,1,0,0,0,0), 16'd2, 16'd2});
    rows.push_back(row_t'{ADD324, LW21,   HALT_I, NOP_I,  1'b0, ctl(1,0,1,0,0,0,0), 16'd2, 16'd2});
    rows.push_back(row_t'{NOP_I,  NOP_I,  LW21,   HALT_I, 1'b0, ctl(1,0,1,0,0,0,0), 16'd2, 16'd2});
    rows.push_back(row_t'{NOP_I,  NOP_I,  NOP_I,  NOP_I,  1'b0, ctl(1,0,1,0,0,0,1), 16'd2, 16'd2});
    rows.push_back(row_t'{ADD324, LW21,   NOP_I,  NOP_I,  1'b0, ctl(1,0,1,0,0,0,1), 16'd2, 16'd2});
    rows.push_back(row_t'{ADD324, LW21,   NOP_I,  NOP_I,  1'b1, ctl(1,0,1,0,0,0,1), 16'd2, 16'd2});
    rows.push_back(row_t'{NOP_I,  NOP_I,  NOP_I,  NOP_I,  1'b0, ctl(1,0,1,0,0,0,1), 16'd2, 16'd2});
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL halt_drain ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      n_checks++;
      if (obs_cnt !== {e.stall, e.flush}) begin
        n_fail++; $display("FAIL halt_drain counters row %0d: got %h want %h", i, obs_cnt, {e.stall, e.flush});
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_reset_in_drain();
    row_t rows[$];
    exp_t e;
    id_ins = NOP_I; ex_ins = NOP_I; dm_ins = NOP_I; wb_ins = NOP_I; ex_redirect = 1'b0;
    rst = 1'b1;
    #2;
    n_checks++;
    if ({obs_ctrl, obs_cnt} !== {ctl(0,0,0,0,0,0,0), 32'h0}) begin
      n_fail++; $display("FAIL reset_from_done: got %b/%h want %b/00000000", obs_ctrl, obs_cnt, ctl(0,0,0,0,0,0,0));
    end
    #1 rst = 1'b0;
    @(posedge clk) #1;
    rows.push_back(row_t'{ADD324, LW21,   NOP_I, NOP_I,  1'b0, ctl(1,1,0,1,0,0,0), 16'd0, 16'd0});
    rows.push_back(row_t'{NOP_I,  NOP_I,  NOP_I, NOP_I,  1'b1, ctl(0,0,1,1,0,0,0), 16'd1, 16'd0});
    rows.push_back(row_t'{HALT_I, NOP_I,  NOP_I, NOP_I,  1'b0, ctl(1,0,1,0,0,0,0), 16'd1, 16'd1});
    rows.push_back(row_t'{NOP_I,  HALT_I, NOP_I, NOP_I,  1'b0, ctl(1,0,1,0,0,0,0), 16'd1, 16'd1});
    rows.push_back(row_t'{NOP_I,  NOP_I,  NOP_I, HALT_I, 1'b0, ctl(0,0,0,0,0,0,0), 16'd0, 16'd0});
    rows.push_back(row_t'{NOP_I,  NOP_I,  NOP_I, NOP_I,  1'b0, ctl(0,0,0,0,0,0,0), 16'd0, 16'd0});
    foreach (rows[i]) begin
      if (i == 4) begin
        // Machine sits in DRAIN with the halt in DM; reset asynchronously mid-cycle.
        id_ins = NOP_I; ex_ins = NOP_I; dm_ins = HALT_I; wb_ins = NOP_I;
        rst = 1'b1;
        #2;
        n_checks++;
        if ({obs_ctrl, obs_cnt} !== {ctl(0,0,0,0,0,0,0), 32'h0}) begin
          n_fail++; $display("FAIL reset_mid_drain: got %b/%h want %b/00000000", obs_ctrl, obs_cnt, ctl(0,0,0,0,0,0,0));
        end
        #1 rst = 1'b0;
        @(posedge clk) #1;
      end
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL reset_drain ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      n_checks++;
      if (obs_cnt !== {e.stall, e.flush}) begin
        n_fail++; $display("FAIL reset_drain counters row %0d: got %h want %h", i, obs_cnt, {e.stall, e.flush});
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_back_to_back_saturation();
    row_t rows[$];
    exp_t e;
    logic [1:0] sat_stall, sat_flush;
    for (int i = 0; i < 5; i++)
      rows.push_back(row_t'{ADD324, LW21, NOP_I, NOP_I, 1'b0, ctl(1,1,0,1,0,0,0), 16'(i), 16'd0});
    for (int i = 0; i < 4; i++)
      rows.push_back(row_t'{NOP_I, NOP_I, NOP_I, NOP_I, 1'b1, ctl(0,0,1,1,0,0,0), 16'd5, 16'(i)});
    rows.push_back(row_t'{NOP_I, NOP_I, NOP_I, NOP_I, 1'b0, ctl(0,0,0,0,0,0,0), 16'd5, 16'd4});
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      sat_stall = (e.stall > 16'd3) ? 2'd3 : e.stall[1:0];
      sat_flush = (e.flush > 16'd3) ? 2'd3 : e.flush[1:0];
      n_checks++;
      if (obs_ctrl !== e.ctrl) begin
        n_fail++; $display("FAIL b2b ctrl row %0d: got %b want %b", i, obs_ctrl, e.ctrl);
      end
      n_checks++;
      if (obs_cnt !== {e.stall, e.flush}) begin
        n_fail++; $display("FAIL b2b counters row %0d: got %h want %h", i, obs_cnt, {e.stall, e.flush});
      end
      n_checks++;
      if ({s_stall_cnt, s_flush_cnt} !== {sat_stall, sat_flush}) begin
        n_fail++; $display("FAIL saturation row %0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                           i, s_stall_cnt, s_flush_cnt, sat_stall, sat_flush);
      end
      @(posedge clk) #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_redirect_over_stall();
    test_redirect_kills_halt();
    test_halt_drain();
    test_reset_in_drain();
    test_back_to_back_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Sequencing controller for the 5-stage IF/ID/EX/DM/WB pipeline.
- Watches the four stage instruction registers (ID/EX/DM/WB) and the branch resolution from EX.
- Produces PC hold, ID hold/flush, EX bubble and operand-forwarding selects.
- Sequences halt drain and the sticky finish flag, and keeps saturating stall/flush event counters for debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt.
HALT_OP, 6'h3F, opcode treated as halt.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
id_ins  in  32  instruction in ID
ex_ins  in  32  instruction in EX
dm_ins  in  32  instruction in DM
wb_ins  in  32  instruction in WB
ex_redirect  in  1  EX resolved a taken branch/jump this cycle
pc_hold  out  1  PC keeps its value
id_hold  out  1  ID register keeps its value
id_flush  out  1  ID register loads NOP (32'h0)
ex_bubble  out  1  EX register loads NOP
fwd_a  out  2  EX rs source: 0 regfile, 1 DM result, 2 WB result
fwd_b  out  2  EX rt source, same encoding
finish  out  1  sticky, high once halt retires
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirect flushes, saturating

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset drives state=RUN, finish=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow from RUN with the given inputs.
- Decode, applied to each stage: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
- Destination register:
  - op 0x00 (R-type): rd.
  - op 0x08..0x0F and 0x23 (lw): rt.
  - All other ops: none.
  - Register 0 is never a destination.
- Source registers:
  - rs is read by all ops except 0x02, 0x03 and HALT_OP.
  - rt is read by R-type, 0x2B (sw), 0x04 and 0x05.
- load_use: ex op=0x23 AND ex rt!=0 AND (ID reads rs==ex rt OR ID reads rt==ex rt).
- Forwarding (combinational, no latency):
  - fwd_a=1 if DM dest==ex rs; else 2 if WB dest==ex rs; else 0. DM has priority over WB.
  - fwd_b is the same rule applied to ex rt.
- FSM states: RUN, DRAIN, DONE. Outputs are combinational from state and inputs; state and counters are registered.
- Priority within a cycle: ex_redirect > load_use > halt detect.
- RUN:
  - ex_redirect=1:
    - id_flush=1, ex_bubble=1, pc_hold=0. The PC takes the redirect target, supplied by the datapath.
    - flush_cnt+1. Any load_use or halt in ID is discarded. Stay RUN.
  - else load_use=1:
    - pc_hold=1, id_hold=1, ex_bubble=1, stall_cnt+1. Stay RUN.
    - Exactly one stall cycle; the next cycle forwards from DM.
  - else ID op==HALT_OP: pc_hold=1, id_flush=1; next state DRAIN.
  - else all controls 0.
- DRAIN:
  - pc_hold=1, id_flush=1; EX/DM/WB advance normally.
  - ex_redirect is ignored: it cannot occur because older instructions have already resolved.
  - When wb op==HALT_OP: finish<=1, next state DONE. This is 3 cycles after entry.
- DONE: pc_hold=1, id_flush=1, finish held at 1 until rst. Counters frozen.
- Counters saturate at all-ones and do not wrap.
- Reset mid-stall or mid-drain returns to RUN immediately. No partial state survives.
- Simultaneous load_use and ex_redirect: flush only; stall_cnt does not increment.

Decomposition:
- Shared package `pipe_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_HALT.
  - NOP constant.
  - fwd select enum: FWD_RF, FWD_DM, FWD_WB.
  - FSM state enum.
- One sub-module, `ins_decode`: purely combinational, instantiated 4×. Maps instruction to {dest_valid, dest, reads_rs, reads_rt, is_lw, is_halt}.

Test Plan:
- load-use: ex=lw $2,0($1), id=add $3,$2,$4 -> pc_hold=id_hold=ex_bubble=1 for exactly 1 cycle; stall_cnt 0->1; next cycle fwd_a=1.
- forwarding priority: dm=add $5,..., wb=addi $5,..., ex=sub $6,$5,$5 -> fwd_a=1, fwd_b=1. With dm dest=$0 and all regs $0 -> fwd 0.
- redirect over stall: ex_redirect=1 with load_use true -> id_flush=ex_bubble=1, pc_hold=0; flush_cnt+1, stall_cnt unchanged.
- halt drain: 32'hFC000000 enters ID -> DRAIN with pc_hold=1; finish rises the cycle after wb op=3F, 3 cycles later; stays 1 in DONE.
- redirect kills halt: halt in ID with ex_redirect=1 -> state stays RUN, finish stays 0.
- reset/saturation: rst pulse in DRAIN -> RUN, finish=0, counters 0. With CNT_W=2 and 5 stalls -> stall_cnt=3.
